rat_ckpt: RTL and testbench

// Multi-lane register alias table with branch checkpoints for the OoO rename stage.
// - Renames WIDTH instructions per cycle, with intra-group RAW/WAW bypass.
// - Saves up to N_CKPT table snapshots, one per predicted branch.
// - Restores a snapshot in one cycle on mispredict.
// - Sits between decode and dispatch; takes new tags from the free list, feeds old tags to the ROB.

---
 rtl/rat_ckpt.sv | 261 ++++++++++++++++++++++++++
 tb/tb_rat_ckpt.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rat_ckpt.sv
// -----------------------------------------------------------------------------
// rat_ckpt : multi-lane register alias table with branch checkpoints
//
// Renames WIDTH instructions per cycle (lane 0 oldest) with intra-group RAW/WAW
// bypass, keeps up to N_CKPT full-table snapshots (one per predicted branch) in
// a circular buffer, and restores a snapshot in one cycle on a mispredict.
//
// Optional feature macro: RAT_FLUSH_EN
//   Adds a retirement RAT (RRAT) updated by commits and a flush input that
//   copies the RRAT into the speculative table and drops every checkpoint.
//
// Ports
//   clk, rst_n                        clock, asynchronous active-low reset
//   ren_valid[WIDTH]                  lane i renames this cycle
//   ren_rs1_arch/ren_rs2_arch[5*W]    source arch regs, lane i at [5i+:5]
//   ren_rd_arch[5*W], ren_rd_we[W]    destination arch reg / write enable
//   ren_rd_new_tag[TAG_W*W]           new physical tag from the free list
//   ren_rs1_tag/ren_rs2_tag           renamed sources (combinational)
//   ren_rd_old_tag                    previous mapping of rd (combinational)
//   ckpt_alloc, ckpt_lane             take a checkpoint after lane ckpt_lane
//   ckpt_id                           slot used by this cycle's allocation
//   ckpt_full                         no free slot (from registers only)
//   br_valid, br_id, br_mispredict    branch resolution: restore or release
//   cmt_valid, cmt_rd_arch,
//   cmt_rd_tag, flush                 (RAT_FLUSH_EN only) commit / flush
// -----------------------------------------------------------------------------
module rat_ckpt #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 128,
  parameter int TAG_W     = $clog2(PHYS_REGS),
  parameter int WIDTH     = 2,
  parameter int N_CKPT    = 4,
  parameter int CKPT_W    = $clog2(N_CKPT),
  parameter int LANE_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       ren_valid,
  input  logic [WIDTH*5-1:0]     ren_rs1_arch,
  input  logic [WIDTH*5-1:0]     ren_rs2_arch,
  input  logic [WIDTH*5-1:0]     ren_rd_arch,
  input  logic [WIDTH-1:0]       ren_rd_we,
  input  logic [WIDTH*TAG_W-1:0] ren_rd_new_tag,
  output logic [WIDTH*TAG_W-1:0] ren_rs1_tag,
  output logic [WIDTH*TAG_W-1:0] ren_rs2_tag,
  output logic [WIDTH*TAG_W-1:0] ren_rd_old_tag,
  input  logic                   ckpt_alloc,
  input  logic [LANE_W-1:0]      ckpt_lane,
  output logic [CKPT_W-1:0]      ckpt_id,
  output logic                   ckpt_full,
  input  logic                   br_valid,
  input  logic [CKPT_W-1:0]      br_id,
  input  logic                   br_mispredict
`ifdef RAT_FLUSH_EN
  ,
  input  logic [WIDTH-1:0]       cmt_valid,
  input  logic [WIDTH*5-1:0]     cmt_rd_arch,
  input  logic [WIDTH*TAG_W-1:0] cmt_rd_tag,
  input  logic                   flush
`endif
);

  // Head/tail carry one extra wrap bit so full and empty are distinguishable.
  localparam int PTR_W = CKPT_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(N_CKPT);

  typedef logic [TAG_W-1:0] tag_t;

  tag_t table_reg  [ARCH_REGS];
  tag_t table_next [ARCH_REGS];
  tag_t renamed    [ARCH_REGS];  // table with this whole group applied
  tag_t snap       [ARCH_REGS];  // table with lanes 0..ckpt_lane applied
  tag_t ckpt_mem   [N_CKPT][ARCH_REGS];

  logic [N_CKPT-1:0] valid_reg, valid_next;
  logic [PTR_W-1:0]  head_reg, head_next;
  logic [PTR_W-1:0]  tail_reg, tail_next;
  logic              ckpt_we;

  logic [4:0]        rs1_a [WIDTH];
  logic [4:0]        rs2_a [WIDTH];
  logic [4:0]        rd_a  [WIDTH];
  tag_t              new_tag [WIDTH];
  logic [WIDTH-1:0]  lane_wr;

  logic [CKPT_W-1:0] head_idx, tail_idx, br_off;
  logic              do_alloc, do_resolve, do_mispredict, do_flush;

  // ---------------------------------------------------------------------------
  // Lane unpacking and per-lane lookup with bypass from older lanes
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
      tag_t rs1_t, rs2_t, old_t;

      assign rs1_a[gi]   = ren_rs1_arch[5*gi +: 5];
      assign rs2_a[gi]   = ren_rs2_arch[5*gi +: 5];
      assign rd_a[gi]    = ren_rd_arch[5*gi +: 5];
      assign new_tag[gi] = ren_rd_new_tag[TAG_W*gi +: TAG_W];
      assign lane_wr[gi] = ren_valid[gi] & ren_rd_we[gi];

      // Ascending scan over older lanes: the youngest matching writer wins.
      always_comb begin
        rs1_t = table_reg[rs1_a[gi]];
        rs2_t = table_reg[rs2_a[gi]];
        old_t = table_reg[rd_a[gi]];
        for (int j = 0; j < WIDTH; j++) begin
          if (j < gi && lane_wr[j]) begin
            if (rd_a[j] == rs1_a[gi]) rs1_t = new_tag[j];
            if (rd_a[j] == rs2_a[gi]) rs2_t = new_tag[j];
            if (rd_a[j] == rd_a[gi])  old_t = new_tag[j];
          end
        end
        // x0 is hardwired; an older lane "writing" x0 must not leak through.
        if (rs1_a[gi] == '0) rs1_t = '0;
        if (rs2_a[gi] == '0) rs2_t = '0;
        if (rd_a[gi]  == '0) old_t = '0;
      end

      assign ren_rs1_tag[TAG_W*gi +: TAG_W]    = rs1_t;
      assign ren_rs2_tag[TAG_W*gi +: TAG_W]    = rs2_t;
      assign ren_rd_old_tag[TAG_W*gi +: TAG_W] = old_t;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Group write-back: full group for the table, prefix up to the branch lane
  // for the snapshot. Later lanes overwrite earlier ones on the same rd.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int r = 0; r < ARCH_REGS; r++) begin
      renamed[r] = table_reg[r];
      snap[r]    = table_reg[r];
      for (int j = 0; j < WIDTH; j++) begin
        if (lane_wr[j] && rd_a[j] == 5'(r) && r != 0) begin
          renamed[r] = new_tag[j];
          if (j <= int'(ckpt_lane)) snap[r] = new_tag[j];
        end
      end
    end
  end

`ifdef RAT_FLUSH_EN
  // ---------------------------------------------------------------------------
  // Retirement RAT; flush reads rrat_next so same-cycle commits are included.
  // ---------------------------------------------------------------------------
  tag_t       rrat_reg  [ARCH_REGS];
  tag_t       rrat_next [ARCH_REGS];
  logic [4:0] cmt_a [WIDTH];
  tag_t       cmt_t [WIDTH];

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cmt
      assign cmt_a[gi] = cmt_rd_arch[5*gi +: 5];
      assign cmt_t[gi] = cmt_rd_tag[TAG_W*gi +: TAG_W];
    end
  endgenerate

  always_comb begin
    for (int r = 0; r < ARCH_REGS; r++) begin
      rrat_next[r] = rrat_reg[r];
      for (int j = 0; j < WIDTH; j++) begin
        if (cmt_valid[j] && cmt_a[j] == 5'(r) && r != 0) rrat_next[r] = cmt_t[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ARCH_REGS; r++) rrat_reg[r] <= TAG_W'(r);
    end else begin
      rrat_reg <= rrat_next;
    end
  end

  assign do_flush = flush;
`else
  assign do_flush = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Checkpoint buffer control
  // ---------------------------------------------------------------------------
  assign head_idx      = head_reg[CKPT_W-1:0];
  assign tail_idx      = tail_reg[CKPT_W-1:0];
  assign ckpt_id       = tail_idx;
  assign ckpt_full     = (tail_reg - head_reg) == PTR_FULL;
  assign do_alloc      = ckpt_alloc & ~ckpt_full;
  assign do_resolve    = br_valid & ~br_mispredict & valid_reg[br_id];
  assign do_mispredict = br_valid &  br_mispredict & valid_reg[br_id];
  // Age of the mispredicted slot relative to the oldest live slot.
  assign br_off        = br_id - head_idx;

  always_comb begin
    logic [CKPT_W-1:0] off;
    off        = '0;
    table_next = renamed;
    valid_next = valid_reg;
    tail_next  = tail_reg;
    ckpt_we    = 1'b0;
    if (do_flush) begin
`ifdef RAT_FLUSH_EN
      table_next = rrat_next;
`endif
      valid_next = '0;
      tail_next  = '0;
    end else if (do_mispredict) begin
      // Restore wins over this cycle's renames and allocation.
      table_next = ckpt_mem[br_id];
      for (int k = 0; k < N_CKPT; k++) begin
        off = CKPT_W'(k) - head_idx;
        if (off >= br_off) valid_next[k] = 1'b0;
      end
      tail_next = head_reg + PTR_W'(br_off) + PTR_ONE;
    end else begin
      if (do_resolve) valid_next[br_id] = 1'b0;
      if (do_alloc) begin
        valid_next[tail_idx] = 1'b1;
        tail_next            = tail_reg + PTR_ONE;
        ckpt_we              = 1'b1;
      end
    end
  end

  // Head skips every released slot it meets, stopping at a live one or tail.
  always_comb begin
    head_next = head_reg;
    if (do_flush) begin
      head_next = '0;
    end else begin
      for (int k = 0; k < N_CKPT; k++) begin
        if (head_next != tail_next && !valid_next[head_next[CKPT_W-1:0]])
          head_next = head_next + PTR_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ARCH_REGS; r++) table_reg[r] <= TAG_W'(r);
      valid_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else begin
      table_reg <= table_next;
      valid_reg <= valid_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
    end
  end

  // Snapshot contents need no reset: a slot is only read while it is valid.
  always_ff @(posedge clk) begin
    if (ckpt_we) ckpt_mem[tail_idx] <= snap;
  end

endmodule

// File: tb/tb_rat_ckpt.sv
// -----------------------------------------------------------------------------
// tb_rat_ckpt : directed, table-driven bench for rat_ckpt (default parameters:
// WIDTH=2, N_CKPT=4, TAG_W=7). Each vector drives one cycle of inputs and
// checks the combinational outputs before the clock edge; the next vector
// observes the resulting state. Hand-written sequences cover async reset and
// (with RAT_FLUSH_EN) commit + flush.
// -----------------------------------------------------------------------------
module tb_rat_ckpt;
  localparam int TAG_W = 7;
  localparam int WIDTH = 2;
  localparam int NV    = 25;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [WIDTH-1:0]       ren_valid;
  logic [WIDTH*5-1:0]     ren_rs1_arch, ren_rs2_arch, ren_rd_arch;
  logic [WIDTH-1:0]       ren_rd_we;
  logic [WIDTH*TAG_W-1:0] ren_rd_new_tag;
  logic [WIDTH*TAG_W-1:0] ren_rs1_tag, ren_rs2_tag, ren_rd_old_tag;
  logic                   ckpt_alloc;
  logic [0:0]             ckpt_lane;
  logic [1:0]             ckpt_id;
  logic                   ckpt_full;
  logic                   br_valid;
  logic [1:0]             br_id;
  logic                   br_mispredict;
`ifdef RAT_FLUSH_EN
  logic [WIDTH-1:0]       cmt_valid;
  logic [WIDTH*5-1:0]     cmt_rd_arch;
  logic [WIDTH*TAG_W-1:0] cmt_rd_tag;
  logic                   flush;
`endif

  rat_ckpt dut (
    .clk(clk), .rst_n(rst_n),
    .ren_valid(ren_valid), .ren_rs1_arch(ren_rs1_arch), .ren_rs2_arch(ren_rs2_arch),
    .ren_rd_arch(ren_rd_arch), .ren_rd_we(ren_rd_we), .ren_rd_new_tag(ren_rd_new_tag),
    .ren_rs1_tag(ren_rs1_tag), .ren_rs2_tag(ren_rs2_tag), .ren_rd_old_tag(ren_rd_old_tag),
    .ckpt_alloc(ckpt_alloc), .ckpt_lane(ckpt_lane), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
    .br_valid(br_valid), .br_id(br_id), .br_mispredict(br_mispredict)
`ifdef RAT_FLUSH_EN
    , .cmt_valid(cmt_valid), .cmt_rd_arch(cmt_rd_arch), .cmt_rd_tag(cmt_rd_tag), .flush(flush)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int rst;                                  // pulse reset before this vector
    int v, we;                                // lane bitmasks
    int s1a, s1b, s2a, s2b, rda, rdb;         // arch regs, lane0/lane1
    int nta, ntb;                             // new tags
    int alloc, lane;
    int brv, brid, brm;
    int e1a, e1b, e2a, e2b, eoa, eob;         // expected tags
    int cid, eid, efull;                      // cid=0: ckpt_id not checked
  } vec_t;

  vec_t vt [NV];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int vec, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got %0d, expected %0d", name, vec, act, exp);
    end
  endtask

  task automatic idle();
    ren_valid = '0; ren_rd_we = '0;
    ren_rs1_arch = '0; ren_rs2_arch = '0; ren_rd_arch = '0; ren_rd_new_tag = '0;
    ckpt_alloc = 1'b0; ckpt_lane = 1'b0;
    br_valid = 1'b0; br_id = '0; br_mispredict = 1'b0;
`ifdef RAT_FLUSH_EN
    cmt_valid = '0; cmt_rd_arch = '0; cmt_rd_tag = '0; flush = 1'b0;
`endif
  endtask

  task automatic apply(input vec_t t);
    ren_valid      = 2'(t.v);
    ren_rd_we      = 2'(t.we);
    ren_rs1_arch   = {5'(t.s1b), 5'(t.s1a)};
    ren_rs2_arch   = {5'(t.s2b), 5'(t.s2a)};
    ren_rd_arch    = {5'(t.rdb), 5'(t.rda)};
    ren_rd_new_tag = {7'(t.ntb), 7'(t.nta)};
    ckpt_alloc     = 1'(t.alloc);
    ckpt_lane      = 1'(t.lane);
    br_valid       = 1'(t.brv);
    br_id          = 2'(t.brid);
    br_mispredict  = 1'(t.brm);
  endtask

  initial begin
    //       rst v  we s1a s1b s2a s2b rda rdb nta ntb al ln bv bid bm  e1a e1b e2a e2b eoa eob cid eid full
    vt[0]  = '{1, 0, 0,  5, 31,  0, 17,  1,  2,  0,  0, 0, 0, 0, 0, 0,   5, 31,  0, 17,  1,  2, 1, 0, 0};
    vt[1]  = '{0, 3, 3,  3,  3,  3,  4,  3,  3, 40, 41, 0, 0, 0, 0, 0,   3, 40,  3,  4,  3, 40, 1, 0, 0};
    vt[2]  = '{0, 0, 0,  3,  3,  7,  0,  3,  9,  0,  0, 0, 0, 0, 0, 0,  41, 41,  7,  0, 41,  9, 1, 0, 0};
    vt[3]  = '{0, 3, 3,  7,  7,  0,  0,  7, 13, 50, 55, 1, 0, 0, 0, 0,   7, 50,  0,  0,  7, 13, 1, 0, 0};
    vt[4]  = '{0, 2, 2,  7,  7,  3,  3,  7,  7,  0, 51, 0, 0, 0, 0, 0,  50, 50, 41, 41, 50, 50, 1, 1, 0};
    vt[5]  = '{0, 1, 1,  7,  7,  0,  0,  7,  7, 52,  0, 0, 0, 1, 0, 1,  51, 52,  0,  0, 51, 52, 1, 1, 0};
    vt[6]  = '{0, 0, 0,  7,  3,  1,  2,  7, 13,  0,  0, 0, 0, 0, 0, 0,  50, 41,  1,  2, 50, 13, 0, 0, 0};
    vt[7]  = '{1, 0, 0,  7,  3, 10, 11, 12, 13,  0,  0, 1, 0, 0, 0, 0,   7,  3, 10, 11, 12, 13, 1, 0, 0};
    vt[8]  = '{0, 0, 0,  0,  0,  0,  0,  0,  0,  0,  0, 1, 0, 0, 0, 0,   0,  0,  0,  0,  0,  0, 1, 1, 0};
    vt[9]  = '{0, 0, 0,  0,  0,  0,  0,  0,  0,  0,  0, 1, 0, 0, 0, 0,   0,  0,  0,  0,  0,  0, 1, 2, 0};
    vt[10] = '{0, 0, 0,  0,  0,  0,  0,  0,  0,  0,  0, 1, 0, 0, 0, 0,   0,  0,  0,  0,  0,  0, 1, 3, 0};
    vt[11] = '{0, 0, 0,  0,  0,  0,  0,  0,  0,  0,  0, 1, 0, 0, 0, 0,   0,  0,  0,  0,  0,  0, 1, 0, 1};
    vt[12] = '{0, 0, 0,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0, 1, 0, 0,   0,  0,  0,  0,  0,  0, 1, 0, 1};
    vt[13] = '{0, 0, 0,  0,  0,  0,  0,  0,  0,  0,  0, 1, 0, 0, 0, 0,   0,  0,  0,  0,  0,  0, 1, 0, 0};
    vt[14] = '{0, 1, 1,  9,  0,  0,  0,  9,  0, 60,  0, 1, 0, 1, 1, 1,   9,  0,  0,  0,  9,  0, 1, 1, 1};
    vt[15] = '{0, 1, 1,  9,  0,  0,  0, 10,  0, 61,  0, 0, 0, 1, 2, 1,   9,  0,  0,  0, 10,  0, 0, 0, 0};
    vt[16] = '{0, 0, 0, 10,  0,  9,  0,  0,  0,  0,  0, 0, 0, 0, 0, 0,  61,  0,  9,  0,  0,  0, 0, 0, 0};
    vt[17] = '{0, 3, 1,  0,  0,  0, 10,  0,  0, 99,  0, 0, 0, 0, 0, 0,   0,  0,  0, 61,  0,  0, 0, 0, 0};
    vt[18] = '{0, 0, 0,  0, 10,  0,  0,  0,  0,  0,  0, 0, 0, 0, 0, 0,   0, 61,  0,  0,  0,  0, 0, 0, 0};
    vt[19] = '{0, 3, 3,  5,  6,  6,  5,  5,  6, 70, 71, 0, 0, 0, 0, 0,   5,  6,  6, 70,  5,  6, 0, 0, 0};
    vt[20] = '{0, 0, 0,  5,  6,  3,  7,  5,  6,  0,  0, 0, 0, 0, 0, 0,  70, 71,  3,  7, 70, 71, 0, 0, 0};
    vt[21] = '{1, 3, 3, 11, 11,  0,  0, 11, 12, 80, 81, 1, 1, 0, 0, 0,  11, 80,  0,  0, 11, 12, 1, 0, 0};
    vt[22] = '{0, 3, 3, 12, 11,  0,  0, 11, 12, 82, 83, 0, 0, 0, 0, 0,  81, 82,  0,  0, 80, 81, 1, 1, 0};
    vt[23] = '{0, 0, 0, 11, 12,  0,  0,  0,  0,  0,  0, 0, 0, 1, 0, 1,  82, 83,  0,  0,  0,  0, 1, 1, 0};
    vt[24] = '{0, 0, 0, 11, 12,  0,  0, 11, 12,  0,  0, 0, 0, 0, 0, 0,  80, 81,  0,  0, 80, 81, 0, 0, 0};

    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int k = 0; k < NV; k++) begin
      @(posedge clk);
      #1;
      if (vt[k].rst != 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      apply(vt[k]);
      #2;
      chk("rs1_tag_l0", k, int'(ren_rs1_tag[6:0]),     vt[k].e1a);
      chk("rs1_tag_l1", k, int'(ren_rs1_tag[13:7]),    vt[k].e1b);
      chk("rs2_tag_l0", k, int'(ren_rs2_tag[6:0]),     vt[k].e2a);
      chk("rs2_tag_l1", k, int'(ren_rs2_tag[13:7]),    vt[k].e2b);
      chk("old_tag_l0", k, int'(ren_rd_old_tag[6:0]),  vt[k].eoa);
      chk("old_tag_l1", k, int'(ren_rd_old_tag[13:7]), vt[k].eob);
      if (vt[k].cid != 0) chk("ckpt_id", k, int'(ckpt_id), vt[k].eid);
      chk("ckpt_full", k, int'(ckpt_full), vt[k].efull);
      $display("vec %0d: rs1 %0d/%0d rs2 %0d/%0d old %0d/%0d id %0d full %0b",
               k, ren_rs1_tag[6:0], ren_rs1_tag[13:7], ren_rs2_tag[6:0], ren_rs2_tag[13:7],
               ren_rd_old_tag[6:0], ren_rd_old_tag[13:7], ckpt_id, ckpt_full);
    end

    // Asynchronous reset mid-operation: table returns to identity without a clock edge.
    @(posedge clk);
    #1;
    idle();
    ren_rs1_arch = {5'd12, 5'd11};
    #1 chk("pre_reset_x11", 100, int'(ren_rs1_tag[6:0]), 80);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_x11",  100, int'(ren_rs1_tag[6:0]),  11);
    chk("async_rst_x12",  100, int'(ren_rs1_tag[13:7]), 12);
    chk("async_rst_id",   100, int'(ckpt_id),   0);
    chk("async_rst_full", 100, int'(ckpt_full), 0);
    $display("async reset: x11 %0d x12 %0d id %0d full %0b",
             ren_rs1_tag[6:0], ren_rs1_tag[13:7], ckpt_id, ckpt_full);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Checkpoints taken before reset are gone: mispredict on id 0 is ignored.
    @(posedge clk);
    #1;
    ren_valid = 2'b01; ren_rd_we = 2'b01; ren_rd_arch = {5'd0, 5'd11};
    ren_rd_new_tag = {7'd0, 7'd90};
    br_valid = 1'b1; br_id = 2'd0; br_mispredict = 1'b1;
    @(posedge clk);
    #1;
    idle();
    ren_rs1_arch = {5'd12, 5'd11};
    #1 chk("lost_ckpt_x11", 101, int'(ren_rs1_tag[6:0]), 90);
    $display("post-reset mispredict: x11 %0d", ren_rs1_tag[6:0]);

`ifdef RAT_FLUSH_EN
    // Commit x4->70, then flush with a same-cycle commit x5->71 while a rename
    // and a mispredict are also presented; flush must win.
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    ren_valid = 2'b01; ren_rd_we = 2'b01; ren_rd_arch = {5'd0, 5'd4};
    ren_rd_new_tag = {7'd0, 7'd33}; ckpt_alloc = 1'b1;
    @(posedge clk);
    #1;
    idle();
    cmt_valid = 2'b01; cmt_rd_arch = {5'd0, 5'd4}; cmt_rd_tag = {7'd0, 7'd70};
    @(posedge clk);
    #1;
    idle();
    cmt_valid = 2'b10; cmt_rd_arch = {5'd5, 5'd0}; cmt_rd_tag = {7'd71, 7'd0};
    ren_valid = 2'b01; ren_rd_we = 2'b01; ren_rd_arch = {5'd0, 5'd6};
    ren_rd_new_tag = {7'd0, 7'd34};
    br_valid = 1'b1; br_id = 2'd0; br_mispredict = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    idle();
    ren_rs1_arch = {5'd5, 5'd4};
    ren_rs2_arch = {5'd0, 5'd6};
    #1;
    chk("flush_x4",   102, int'(ren_rs1_tag[6:0]),  70);
    chk("flush_x5",   102, int'(ren_rs1_tag[13:7]), 71);
    chk("flush_x6",   102, int'(ren_rs2_tag[6:0]),  6);
    chk("flush_id",   102, int'(ckpt_id),   0);
    chk("flush_full", 102, int'(ckpt_full), 0);
    $display("flush: x4 %0d x5 %0d x6 %0d id %0d full %0b",
             ren_rs1_tag[6:0], ren_rs1_tag[13:7], ren_rs2_tag[6:0], ckpt_id, ckpt_full);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
